// File: rtl/bp_pkg.sv
// bp_pkg: shared counter type, mode constants and counter step function for the branch predictor
package bp_pkg;
   typedef logic [1:0] ctr_t;
   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;
   localparam int BP_BIMODAL = 0;
   localparam int BP_GSHARE  = 1;
   function automatic ctr_t ctr_next(ctr_t c, logic taken);
      return taken ? ((c == CTR_ST) ? c : c + 2'd1) : ((c == CTR_SNT) ? c : c - 2'd1);
   endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX training and perf counter signals of the predictor
interface branch_predictor_if #(parameter int XLEN = 16, parameter int CNT_W = 16);
   logic [XLEN-1:0]  pc;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             upd_valid;
   logic [XLEN-1:0]  upd_pc;
   logic             upd_taken;
   logic [XLEN-1:0]  upd_target;
   logic             upd_mispred;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_miss;
   modport master (output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
                   input pred_taken, pred_target, cnt_branch, cnt_miss);
   modport slave (input pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
                  output pred_taken, pred_target, cnt_branch, cnt_miss);
endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: up-counter with enable that sticks at all-ones
module bp_sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (reset) q <= '0;
      else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus 2-bit counter table, bimodal or gshare indexed
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN     = 16,
   parameter int IDX_BITS = 4,
   parameter int TAG_BITS = 4,
   parameter int GHR_BITS = 4,
   parameter int MODE     = 0,
   parameter int CNT_W    = 16
) (
   input logic              clk,
   input logic              reset,
   branch_predictor_if.slave bus
);
   localparam int N = 1 << IDX_BITS;
   logic [N-1:0]        valid;
   logic [TAG_BITS-1:0] tag [N];
   logic [XLEN-1:0]     target [N];
   ctr_t                ctr [N];
   logic [GHR_BITS-1:0] ghr;
   logic [IDX_BITS-1:0] ghr_x, r_bidx, r_cidx, u_bidx, u_cidx;
   logic [TAG_BITS-1:0] r_tag, u_tag;
   logic                hit;
   assign ghr_x  = IDX_BITS'(ghr);
   assign r_bidx = bus.pc[IDX_BITS-1:0];
   assign u_bidx = bus.upd_pc[IDX_BITS-1:0];
   assign r_tag  = bus.pc[IDX_BITS +: TAG_BITS];
   assign u_tag  = bus.upd_pc[IDX_BITS +: TAG_BITS];
   assign r_cidx = (MODE == BP_GSHARE) ? r_bidx ^ ghr_x : r_bidx;
   assign u_cidx = (MODE == BP_GSHARE) ? u_bidx ^ ghr_x : u_bidx;
   // Lookup reads only registered state, so a same-cycle update is seen next cycle
   always_comb begin
      hit             = valid[r_bidx] && (tag[r_bidx] == r_tag);
      bus.pred_taken  = hit && ctr[r_cidx][1];
      bus.pred_target = bus.pred_taken ? target[r_bidx] : '0;
   end
   always_ff @(posedge clk)
      if (reset) begin
         valid <= '0;
         ghr   <= '0;
         for (int i = 0; i < N; i++) ctr[i] <= CTR_WNT;
      end else if (bus.upd_valid) begin
         ctr[u_cidx] <= ctr_next(ctr[u_cidx], bus.upd_taken);
         ghr         <= (ghr << 1) | GHR_BITS'(bus.upd_taken);
         if (bus.upd_taken) valid[u_bidx] <= 1'b1;
      end
   // Payload needs no reset: it is only observed behind a valid bit
   always_ff @(posedge clk)
      if (!reset && bus.upd_valid && bus.upd_taken) begin
         tag[u_bidx]    <= u_tag;
         target[u_bidx] <= bus.upd_target;
      end
   bp_sat_counter #(.W(CNT_W)) u_branch (
      .clk   (clk),
      .reset (reset),
      .en    (bus.upd_valid),
      .q     (bus.cnt_branch)
   );
   bp_sat_counter #(.W(CNT_W)) u_miss (
      .clk   (clk),
      .reset (reset),
      .en    (bus.upd_valid && bus.upd_mispred),
      .q     (bus.cnt_miss)
   );
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus, queued expectations checked by a negedge monitor
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0, upd_pc = '0, upd_target = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
  logic        done = 1'b0;
  always #5 clk = ~clk;
  branch_predictor_if #(.XLEN(16), .CNT_W(16)) ba ();
  branch_predictor_if #(.XLEN(16), .CNT_W(16)) bg ();
  branch_predictor_if #(.XLEN(16), .CNT_W(2))  bc ();
  assign ba.pc = pc;
  assign ba.upd_valid = upd_valid;
  assign ba.upd_pc = upd_pc;
  assign ba.upd_taken = upd_taken;
  assign ba.upd_target = upd_target;
  assign ba.upd_mispred = upd_mispred;
  assign bg.pc = pc;
  assign bg.upd_valid = upd_valid;
  assign bg.upd_pc = upd_pc;
  assign bg.upd_taken = upd_taken;
  assign bg.upd_target = upd_target;
  assign bg.upd_mispred = upd_mispred;
  assign bc.pc = pc;
  assign bc.upd_valid = upd_valid;
  assign bc.upd_pc = upd_pc;
  assign bc.upd_taken = upd_taken;
  assign bc.upd_target = upd_target;
  assign bc.upd_mispred = upd_mispred;
  branch_predictor #(.XLEN(16), .IDX_BITS(4), .TAG_BITS(4), .GHR_BITS(4), .MODE(0), .CNT_W(16))
    dut_a (.clk(clk), .reset(rst), .bus(ba));
  branch_predictor #(.XLEN(16), .IDX_BITS(4), .TAG_BITS(4), .GHR_BITS(4), .MODE(1), .CNT_W(16))
    dut_g (.clk(clk), .reset(rst), .bus(bg));
  branch_predictor #(.XLEN(16), .IDX_BITS(4), .TAG_BITS(4), .GHR_BITS(4), .MODE(0), .CNT_W(2))
    dut_c (.clk(clk), .reset(rst), .bus(bc));
  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;
  chk_t q[$];
  chk_t c;
  int total = 0, bad = 0;
  function automatic logic [15:0] actual(int sel);
    case (sel)
      0: return {15'd0, ba.pred_taken};
      1: return ba.pred_target;
      2: return ba.cnt_branch;
      3: return ba.cnt_miss;
      4: return {15'd0, bg.pred_taken};
      5: return bg.pred_target;
      default: return {14'd0, bc.cnt_branch};
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0) begin
      c = q.pop_front();
      total++;
      if (actual(c.sel) !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", c.name, actual(c.sel), c.exp);
      end
    end
  task automatic expect_v(input int sel, input logic [15:0] e, input string n);
    q.push_back('{sel, e, n});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_mispred = 1'b0;
  endtask
  task automatic upd(input logic [15:0] p, input logic t, input logic [15:0] tg, input logic m);
    upd_valid = 1'b1;
    upd_pc = p;
    upd_taken = t;
    upd_target = tg;
    upd_mispred = m;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #20000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: stimulus did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end
  initial begin
    do_reset();
    #1;
    total++;
    if (ba.pred_taken !== 1'b0 || ba.pred_target !== 16'h0 || ba.cnt_branch !== 16'h0 ||
        ba.cnt_miss !== 16'h0 || bc.cnt_branch !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: pt=%b tgt=%h cb=%h cm=%h cbn=%h", ba.pred_taken,
               ba.pred_target, ba.cnt_branch, ba.cnt_miss, bc.cnt_branch);
    end
    pc = 16'h0013;
    expect_v(0, 16'h0, "rst_pt");
    expect_v(1, 16'h0, "rst_tgt");
    expect_v(2, 16'h0, "rst_cb");
    expect_v(3, 16'h0, "rst_cm");
    expect_v(6, 16'h0, "rst_cb_narrow");
    tick();
    upd(16'h0013, 1'b1, 16'h0040, 1'b0);
    tick();
    expect_v(0, 16'h1, "bim_pt");
    expect_v(1, 16'h0040, "bim_tgt");
    expect_v(2, 16'd1, "bim_cb");
    tick();
    repeat (3) begin
      upd(16'h0013, 1'b0, 16'h0000, 1'b0);
      tick();
    end
    expect_v(0, 16'h0, "sat_pt");
    expect_v(1, 16'h0, "sat_tgt");
    expect_v(2, 16'd4, "sat_cb");
    expect_v(6, 16'd3, "narrow_sat4");
    tick();
    repeat (2) begin
      upd(16'h0013, 1'b1, 16'h0040, 1'b0);
      tick();
    end
    upd(16'h0023, 1'b1, 16'h0050, 1'b0);
    tick();
    expect_v(0, 16'h0, "alias_old_pt");
    tick();
    pc = 16'h0023;
    expect_v(0, 16'h1, "alias_new_pt");
    expect_v(1, 16'h0050, "alias_new_tgt");
    tick();
    pc = 16'h0013;
    upd(16'h0013, 1'b1, 16'h0040, 1'b0);
    expect_v(0, 16'h0, "coll_same_pt");
    expect_v(1, 16'h0, "coll_same_tgt");
    tick();
    expect_v(0, 16'h1, "coll_next_pt");
    expect_v(1, 16'h0040, "coll_next_tgt");
    expect_v(2, 16'd8, "coll_cb");
    tick();
    rst = 1'b1;
    upd(16'h0033, 1'b1, 16'h0077, 1'b1);
    tick();
    rst = 1'b0;
    pc = 16'h0033;
    expect_v(0, 16'h0, "rstupd_pt");
    expect_v(1, 16'h0, "rstupd_tgt");
    expect_v(2, 16'h0, "rstupd_cb");
    expect_v(3, 16'h0, "rstupd_cm");
    tick();
    pc = 16'h0013;
    expect_v(0, 16'h0, "rst_cleared_pt");
    tick();
    for (int i = 0; i < 10; i++) begin
      upd(16'h0060 + 16'(i), (i % 2) == 1, 16'h0080 + 16'(i), (i % 3) == 1);
      if (i == 5) begin
        expect_v(2, 16'd5, "perf_cb5");
        expect_v(6, 16'd3, "narrow_sat5");
      end
      tick();
    end
    expect_v(2, 16'd10, "perf_cb10");
    expect_v(3, 16'd3, "perf_cm3");
    tick();
    do_reset();
    pc = 16'h0005;
    for (int i = 0; i < 16; i++) begin
      upd(16'h0005, (i % 2) == 0, 16'h0009, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      expect_v(4, (k % 2 == 0) ? 16'h1 : 16'h0, "gs_pt");
      expect_v(5, (k % 2 == 0) ? 16'h0009 : 16'h0, "gs_tgt");
      expect_v(0, (k % 2 == 0) ? 16'h0 : 16'h1, "bim_alt_pt");
      upd(16'h0005, (k % 2) == 0, 16'h0009, 1'b0);
      tick();
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined core.
- Replaces the fixed, single-mode jump prediction in fetch with a direct-mapped BTB and a table of 2-bit saturating counters.
- Selectable bimodal or gshare indexing, plus saturating performance counters.
- Fetch queries it combinationally with the current pc; the EX stage trains it when a jump or branch resolves.

Parameters:
- XLEN, 16, width of pc and target addresses (word addresses).
- IDX_BITS, 4, log2 of entry count for both the BTB and the counter table.
- TAG_BITS, 4, BTB tag width; tag = pc[IDX_BITS +: TAG_BITS]; IDX_BITS+TAG_BITS <= XLEN.
- GHR_BITS, 4, global history length; GHR_BITS <= IDX_BITS.
- MODE, 0, 0 = bimodal, 1 = gshare.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc  in  XLEN  fetch address being predicted
- pred_taken  out  1  predict taken this cycle
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0
- upd_valid  in  1  a branch/jump resolved in EX this cycle
- upd_pc  in  XLEN  address of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target
- upd_mispred  in  1  EX detected a direction or target mispredict
- cnt_branch  out  CNT_W  resolved branches since reset
- cnt_miss  out  CNT_W  mispredicts since reset

Behaviour:
- Storage, 2^IDX_BITS entries each:
  - BTB: valid, tag, target.
  - CTR: 2-bit counter.
  - GHR: GHR_BITS shift register.
- Indexing:
  - bidx(a) = a[IDX_BITS-1:0].
  - cidx(a) = bidx(a) when MODE=0; bidx(a) XOR zero-extended GHR when MODE=1.
- Prediction, zero latency, combinational from registered state:
  - hit = valid[bidx(pc)] && tag matches.
  - pred_taken = hit && CTR[cidx(pc)][1].
  - pred_target = BTB target when pred_taken, else 0.
- Update, on the rising clk when upd_valid=1, all fields computed from pre-edge state:
  - CTR[cidx(upd_pc)]: +1 if upd_taken, saturating at 3; -1 if not taken, saturating at 0.
  - If upd_taken: write BTB[bidx(upd_pc)] = {1, tag, upd_target}. This overwrites any aliasing entry (direct-mapped, no replacement policy).
  - If not taken: BTB is untouched; a not-taken branch never allocates.
  - GHR <= {GHR[GHR_BITS-2:0], upd_taken}. GHR is updated non-speculatively, at resolve only.
  - cnt_branch += 1; cnt_miss += upd_mispred. Both saturate at all-ones and never wrap.
- Read/update collision: same-cycle read and update of the same entry makes the prediction use the old value. There is no write-to-read bypass; the new value is visible the next cycle.
- upd_mispred is informational; this block does no flush control. Fetch/ifid own pc redirect.
- Reset:
  - Clears all valid bits.
  - Sets all CTR entries to 2'b01 (weakly not-taken).
  - Clears GHR and both perf counters.
  - After the reset edge: pred_taken=0, pred_target=0, cnt_*=0.
  - Reset asserted mid-training discards all training. Reset has priority over a simultaneous upd_valid.
- Stall: none internally. Fetch holds pc; a repeated lookup is side-effect free.

Decomposition:
- Package bp_pkg:
  - typedef ctr_t (2-bit) with constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - Mode constants BP_BIMODAL=0, BP_GSHARE=1.
  - Function ctr_next(ctr_t, logic taken).
- Sub-module bp_sat_counter, width parameter: saturating up-counter with enable. It is instantiated twice, for cnt_branch and cnt_miss.
- Tables stay as register arrays in the top module, with reset loops.

Test Plan:
- Reset, then pc=0x0013 -> pred_taken=0, pred_target=0, cnt_branch=0.
- Bimodal: one update {upd_pc=0x0013, taken=1, target=0x0040}, then pc=0x0013 -> CTR goes 1->2, hit, pred_taken=1, pred_target=0x0040. Three further not-taken updates -> counter steps 2->1->0->0 (saturates), pred_taken=0, and the BTB entry stays valid.
- Alias: train 0x0013 to taken/0x0040, then a taken update at 0x0023 with target 0x0050 -> pc=0x0013 misses (pred_taken=0), pc=0x0023 predicts 0x0050.
- Collision: pc=0x0013 with an update of the same entry in the same cycle -> old prediction (0) that cycle, new prediction (1/0x0040) the next cycle.
- Gshare (MODE=1): an alternating taken/not-taken branch at 0x0005 (target 0x0009), trained 16 times -> pred_taken alternates correctly afterwards. Bimodal on the same stimulus mispredicts at least 50%.
- Perf/reset:
  - 10 updates, 3 with upd_mispred -> cnt_branch=10, cnt_miss=3.
  - Assert reset in the same cycle as upd_valid -> next cycle all outputs 0 and the entry is not trained.
  - With CNT_W=2 and 5 updates -> cnt_branch holds 3.
